pulse_sequencer: RTL and testbench
==================================

Name: pulse_sequencer

Overview:
Parametrised, runtime-programmable pulse/trigger generator. It is the successor to the fixed power-on one-shot enable used to fire the buzzer SOS pattern. After a programmable start delay it emits one pulse (one-shot mode) or a train of pulses (periodic mode). Pulse width, gap and repeat count are configurable, and the block supports Abort, Busy/Done status and an optional auto-start after reset. It sits between the board clock domain and pattern consumers such as buzzer, LED and sampling-strobe modules.

Parameters:
CNT_W, 28, width of the delay, pulse-length and gap counters and of their config inputs.
REP_W, 8, width of Repeat_Num and Pulse_Cnt.
AUTO_START, 0, 1 = behave as if Start=1 in the first cycle after RST deasserts (once per reset).

Ports:
CLK  in  1  system clock (50 MHz board clock); all logic on rising edge.
RST  in  1  synchronous reset, active-high.
Start  in  1  level-sampled start request; accepted only in IDLE.
Abort  in  1  stop the sequence immediately; priority over Start.
Mode  in  1  0 = one-shot, 1 = periodic.
Delay_Val  in  CNT_W  start delay D, in cycles.
Pulse_Len  in  CNT_W  pulse high width L in cycles; 0 is treated as 1.
Gap_Val  in  CNT_W  low time between pulses = G+1 cycles.
Repeat_Num  in  REP_W  pulses in periodic mode; 0 = run until Abort.
Pulse_Out  out  1  generated pulse (registered).
Busy  out  1  high while DELAY, PULSE or GAP.
Done  out  1  one-cycle strobe at normal completion.
Pulse_Cnt  out  REP_W  pulses completed since last accepted start.

Behaviour:
- Reset (RST=1 at an edge): state IDLE, Pulse_Out=0, Busy=0, Done=0, Pulse_Cnt=0, counters 0, auto-start flag re-armed. Applies mid-sequence; no Done is produced.
- States: IDLE, DELAY, PULSE, GAP. Busy is a registered decode of state != IDLE.
- Start acceptance at edge E0 (IDLE, Start=1, Abort=0, or auto-start flag):
  - latch Mode, D, L, G and Repeat_Num;
  - clear Pulse_Cnt and Count;
  - go to DELAY; Busy=1 after E0.
  - Inputs are then ignored until IDLE. Start outside IDLE is ignored.
- DELAY: Count increments each edge. At the edge where Count==D: go to PULSE, Count<=0, Pulse_Out<=1. The first Pulse_Out rise therefore occurs D+1 edges after E0. With D=0, Pulse_Out is high after E0+1.
- PULSE: Pulse_Out stays high for exactly L cycles (1 if L=0). At the edge where Count==L-1:
  - Pulse_Cnt increments and Pulse_Out<=0.
  - If Mode=0, or Repeat_Num!=0 and the new Pulse_Cnt==Repeat_Num: go to IDLE, Done<=1 for one cycle, Busy<=0 on the same edge.
  - Otherwise go to GAP with Count<=0.
- GAP: Pulse_Out low for G+1 cycles. At the edge where Count==G: go to PULSE, Count<=0, Pulse_Out<=1.
- Period in periodic mode = L + G + 1 cycles.
- Abort=1 in DELAY, PULSE or GAP: at that edge go to IDLE, Pulse_Out<=0, Busy<=0, no Done. Pulse_Cnt holds, and does not count the aborted partial pulse. Abort in IDLE has no effect but blocks a simultaneous Start.
- Pulse_Cnt wraps modulo 2^REP_W in infinite mode. Pulse_Cnt and Done are not cleared by Abort; Pulse_Cnt is cleared only by reset or Start acceptance.
- Comparisons use full CNT_W width with no saturation. D = 2^CNT_W-1 is legal.
- Legacy use: AUTO_START=1, Mode=0, D=99_999_999, L=1 gives a single 1-cycle enable 100,000,000 cycles (2 s) after reset release.

Test Plan:
1. AUTO_START=1, Mode=0, D=9, L=1, RST released before edge E0 -> Pulse_Out high only in the cycle after E0+10; Done in the same cycle as the fall; Busy 0 after; no further pulses in 200 cycles.
2. Mode=1, D=3, L=2, G=1, Repeat=3, Start at E0 -> Pulse_Out per cycle after E0: 0000 11 00 11 00 11 0; Done once at the final fall; Pulse_Cnt=3; Busy low after the final pulse.
3. Mode=1, Repeat=0, D=0, L=1, G=0 -> Pulse_Out alternates 1,0 indefinitely. Abort during the 6th pulse -> Pulse_Out 0 next cycle, no Done, Busy 0, Pulse_Cnt=5.
4. Start held high and config inputs changed during a run -> waveform matches the latched config; no restart until IDLE. Start with Abort in IDLE -> stays IDLE.
5. RST pulsed for 1 cycle mid-PULSE -> all outputs 0 after that edge. With AUTO_START=1, the sequence restarts from DELAY; with AUTO_START=0, the block stays IDLE.
6. D=0, L=0, Mode=0 -> Pulse_Out high exactly 1 cycle, rising after E0+1; Pulse_Cnt=1; Done coincident with the fall.

Source files
------------

// File: rtl/pulse_sequencer.sv
// ---------------------------------------------------------------------------
// pulse_sequencer
//
// Runtime-programmable pulse / trigger generator. After a programmable start
// delay it emits a single pulse (one-shot) or a train of pulses (periodic).
// Pulse width, gap and repeat count are latched when a start is accepted, so
// the config inputs may change freely while a sequence is running.
//
// Ports
//   CLK         system clock, all logic on the rising edge
//   RST         synchronous reset, active-high
//   Start       level start request, honoured only in IDLE
//   Abort       stop immediately (no Done); beats a simultaneous Start
//   Mode        0 = one-shot, 1 = periodic
//   Delay_Val   start delay D in cycles (first rise D+1 edges after start)
//   Pulse_Len   pulse high width L in cycles (0 behaves as 1)
//   Gap_Val     low time between pulses is G+1 cycles
//   Repeat_Num  pulse count in periodic mode, 0 = run until Abort
//   Pulse_Out   registered pulse output
//   Busy        registered, high while DELAY / PULSE / GAP
//   Done        one-cycle strobe on normal completion
//   Pulse_Cnt   pulses completed since the last accepted start
// ---------------------------------------------------------------------------
module pulse_sequencer #(
    parameter int CNT_W      = 28,
    parameter int REP_W      = 8,
    parameter int AUTO_START = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic             Abort,
    input  logic             Mode,
    input  logic [CNT_W-1:0] Delay_Val,
    input  logic [CNT_W-1:0] Pulse_Len,
    input  logic [CNT_W-1:0] Gap_Val,
    input  logic [REP_W-1:0] Repeat_Num,
    output logic             Pulse_Out,
    output logic             Busy,
    output logic             Done,
    output logic [REP_W-1:0] Pulse_Cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   delay_q, delay_d;
    // Stores L-1 (with L=0 folded to 0) so the PULSE exit test is a plain compare.
    logic [CNT_W-1:0]   len_m1_q, len_m1_d;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [REP_W-1:0]   pulse_cnt_q, pulse_cnt_d;
    logic               pulse_q, pulse_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    // Armed by reset; acts as a Start in the first non-reset cycle only.
    logic               auto_q, auto_d;

    logic               start_req;
    logic [REP_W-1:0]   pulse_cnt_inc;

    assign start_req     = (Start | auto_q) & ~Abort;
    assign pulse_cnt_inc = pulse_cnt_q + REP_W'(1);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mode_d      = mode_q;
        delay_d     = delay_q;
        len_m1_d    = len_m1_q;
        gap_d       = gap_q;
        rep_d       = rep_q;
        pulse_cnt_d = pulse_cnt_q;
        pulse_d     = pulse_q;
        done_d      = 1'b0;
        auto_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    mode_d      = Mode;
                    delay_d     = Delay_Val;
                    len_m1_d    = (Pulse_Len == '0) ? '0 : Pulse_Len - CNT_W'(1);
                    gap_d       = Gap_Val;
                    rep_d       = Repeat_Num;
                    pulse_cnt_d = '0;
                    count_d     = '0;
                    state_d     = ST_DELAY;
                end
            end

            ST_DELAY: begin
                if (Abort) begin
                    state_d = ST_IDLE;
                    pulse_d = 1'b0;
                end else if (count_q == delay_q) begin
                    state_d = ST_PULSE;
                    count_d = '0;
                    pulse_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end

            ST_PULSE: begin
                if (Abort) begin
                    // The partial pulse is not counted.
                    state_d = ST_IDLE;
                    pulse_d = 1'b0;
                end else if (count_q == len_m1_q) begin
                    pulse_d     = 1'b0;
                    pulse_cnt_d = pulse_cnt_inc;
                    if (!mode_q || (rep_q != '0 && pulse_cnt_inc == rep_q)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                        count_d = '0;
                    end
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end

            ST_GAP: begin
                if (Abort) begin
                    state_d = ST_IDLE;
                    pulse_d = 1'b0;
                end else if (count_q == gap_q) begin
                    state_d = ST_PULSE;
                    count_d = '0;
                    pulse_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                pulse_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            mode_q      <= 1'b0;
            delay_q     <= '0;
            len_m1_q    <= '0;
            gap_q       <= '0;
            rep_q       <= '0;
            pulse_cnt_q <= '0;
            pulse_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            auto_q      <= (AUTO_START != 0);
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            delay_q     <= delay_d;
            len_m1_q    <= len_m1_d;
            gap_q       <= gap_d;
            rep_q       <= rep_d;
            pulse_cnt_q <= pulse_cnt_d;
            pulse_q     <= pulse_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            auto_q      <= auto_d;
        end
    end

    assign Pulse_Out = pulse_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Pulse_Cnt = pulse_cnt_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pulse_sequencer
//
// Directed bench for pulse_sequencer. Two instances share the stimulus:
// dut_m (AUTO_START=0) and dut_a (AUTO_START=1), each with its own reset so
// one can be parked while the other is exercised. A per-cycle vector table
// covers a periodic run with held Start / changing config and IDLE Start vs
// Abort; hand-written sequences cover the remaining multi-cycle cases.
// ---------------------------------------------------------------------------
module tb_pulse_sequencer;

    localparam int CNT_W = 28;
    localparam int REP_W = 8;

    logic             clk;
    logic             rst_m, rst_a;
    logic             start, abort, mode;
    logic [CNT_W-1:0] d_val, l_val, g_val;
    logic [REP_W-1:0] rep;

    logic             pulse_m, busy_m, done_m;
    logic [REP_W-1:0] cnt_m;
    logic             pulse_a, busy_a, done_a;
    logic [REP_W-1:0] cnt_a;

    int checks = 0;
    int errors = 0;

    pulse_sequencer #(.CNT_W(CNT_W), .REP_W(REP_W), .AUTO_START(0)) dut_m (
        .CLK(clk), .RST(rst_m), .Start(start), .Abort(abort), .Mode(mode),
        .Delay_Val(d_val), .Pulse_Len(l_val), .Gap_Val(g_val), .Repeat_Num(rep),
        .Pulse_Out(pulse_m), .Busy(busy_m), .Done(done_m), .Pulse_Cnt(cnt_m)
    );

    pulse_sequencer #(.CNT_W(CNT_W), .REP_W(REP_W), .AUTO_START(1)) dut_a (
        .CLK(clk), .RST(rst_a), .Start(start), .Abort(abort), .Mode(mode),
        .Delay_Val(d_val), .Pulse_Len(l_val), .Gap_Val(g_val), .Repeat_Num(rep),
        .Pulse_Out(pulse_a), .Busy(busy_a), .Done(done_a), .Pulse_Cnt(cnt_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             start;
        logic             abort;
        logic             mode;
        logic [CNT_W-1:0] d;
        logic [CNT_W-1:0] l;
        logic [CNT_W-1:0] g;
        logic [REP_W-1:0] rep;
        logic             e_pulse;
        logic             e_busy;
        logic             e_done;
        logic [REP_W-1:0] e_cnt;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic s, input logic a, input logic m,
                                input int d, input int l, input int g, input int r,
                                input logic ep, input logic eb, input logic ed,
                                input int ec);
        vec_t v;
        v.start   = s;
        v.abort   = a;
        v.mode    = m;
        v.d       = CNT_W'(d);
        v.l       = CNT_W'(l);
        v.g       = CNT_W'(g);
        v.rep     = REP_W'(r);
        v.e_pulse = ep;
        v.e_busy  = eb;
        v.e_done  = ed;
        v.e_cnt   = REP_W'(ec);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_m(input string name, input logic p, input logic b,
                         input logic dn, input int c);
        chk({name, ".pulse"}, int'(pulse_m), int'(p));
        chk({name, ".busy"},  int'(busy_m),  int'(b));
        chk({name, ".done"},  int'(done_m),  int'(dn));
        chk({name, ".cnt"},   int'(cnt_m),   c);
        $display("%t %s pulse=%0b busy=%0b done=%0b cnt=%0d", $time, name,
                 pulse_m, busy_m, done_m, cnt_m);
    endtask

    task automatic chk_a(input string name, input logic p, input logic b,
                         input logic dn, input int c);
        chk({name, ".pulse"}, int'(pulse_a), int'(p));
        chk({name, ".busy"},  int'(busy_a),  int'(b));
        chk({name, ".done"},  int'(done_a),  int'(dn));
        chk({name, ".cnt"},   int'(cnt_a),   c);
        $display("%t %s pulse=%0b busy=%0b done=%0b cnt=%0d", $time, name,
                 pulse_a, busy_a, done_a, cnt_a);
    endtask

    task automatic set_cfg(input logic m, input int d, input int l, input int g,
                           input int r);
        mode  = m;
        d_val = CNT_W'(d);
        l_val = CNT_W'(l);
        g_val = CNT_W'(g);
        rep   = REP_W'(r);
    endtask

    initial begin
        int bad;

        // Row i: inputs applied before edge E0+i, outputs expected after it.
        // Rows 1..13 hold Start high with a different config that must be ignored.
        tbl[0]  = mk(1, 0, 1, 3, 2, 1, 3,  0, 1, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0, 0, 1,  0, 1, 0, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0);
        tbl[5]  = mk(1, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0);
        tbl[6]  = mk(1, 0, 0, 0, 0, 0, 1,  0, 1, 0, 1);
        tbl[7]  = mk(1, 0, 0, 0, 0, 0, 1,  0, 1, 0, 1);
        tbl[8]  = mk(1, 0, 0, 0, 0, 0, 1,  1, 1, 0, 1);
        tbl[9]  = mk(1, 0, 0, 0, 0, 0, 1,  1, 1, 0, 1);
        tbl[10] = mk(1, 0, 0, 0, 0, 0, 1,  0, 1, 0, 2);
        tbl[11] = mk(1, 0, 0, 0, 0, 0, 1,  0, 1, 0, 2);
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 1,  1, 1, 0, 2);
        tbl[13] = mk(1, 0, 0, 0, 0, 0, 1,  1, 1, 0, 2);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 3);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 3);
        tbl[16] = mk(1, 1, 0, 0, 0, 0, 1,  0, 0, 0, 3);   // Start+Abort in IDLE
        tbl[17] = mk(1, 0, 0, 5, 1, 0, 1,  0, 1, 0, 0);   // accepted, count cleared
        tbl[18] = mk(0, 1, 0, 5, 1, 0, 1,  0, 0, 0, 0);   // abort in DELAY

        rst_m = 1'b1;
        rst_a = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        set_cfg(1'b0, 0, 0, 0, 0);

        // Reset wins over a Start presented at the same edge.
        tick();
        tick();
        chk_m("reset_m", 0, 0, 0, 0);
        chk_a("reset_a", 0, 0, 0, 0);

        start = 1'b0;
        rst_m = 1'b0;
        tick();
        chk_m("idle_after_reset", 0, 0, 0, 0);

        // Periodic 3-pulse run, held Start, IDLE Start/Abort interaction.
        for (int i = 0; i < 19; i++) begin
            start = tbl[i].start;
            abort = tbl[i].abort;
            set_cfg(tbl[i].mode, int'(tbl[i].d), int'(tbl[i].l), int'(tbl[i].g),
                    int'(tbl[i].rep));
            tick();
            chk_m($sformatf("vec%0d", i), tbl[i].e_pulse, tbl[i].e_busy,
                  tbl[i].e_done, int'(tbl[i].e_cnt));
        end
        start = 1'b0;
        abort = 1'b0;

        // Infinite train D=0 L=1 G=0, abort while the 6th pulse is high.
        set_cfg(1'b1, 0, 1, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_m("inf_e0", 0, 1, 0, 0);
        for (int k = 1; k <= 11; k++) begin
            tick();
            chk($sformatf("inf_pulse%0d", k), int'(pulse_m), k % 2);
            chk($sformatf("inf_done%0d", k), int'(done_m), 0);
        end
        chk("inf_cnt_before_abort", int'(cnt_m), 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_m("inf_abort", 0, 0, 0, 5);
        tick();
        chk_m("inf_after_abort", 0, 0, 0, 5);

        // D=0, L=0 one-shot: single one-cycle pulse.
        set_cfg(1'b0, 0, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_m("min_e0", 0, 1, 0, 0);
        tick();
        chk_m("min_e1", 1, 1, 0, 0);
        tick();
        chk_m("min_e2", 0, 0, 1, 1);
        tick();
        chk_m("min_e3", 0, 0, 0, 1);

        // Reset mid-PULSE with a nonzero count, no auto-start: stays IDLE.
        set_cfg(1'b1, 0, 3, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        chk_m("rst_mid_pre", 1, 1, 0, 1);
        rst_m = 1'b1;
        tick();
        rst_m = 1'b0;
        chk_m("rst_mid_m", 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_m($sformatf("rst_idle_m%0d", k), 0, 0, 0, 0);
        end

        // Auto-start one-shot after reset release: D=9, L=1.
        set_cfg(1'b0, 9, 1, 0, 0);
        rst_a = 1'b0;
        tick();
        chk_a("auto_e0", 0, 1, 0, 0);
        bad = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (pulse_a !== 1'b0 || busy_a !== 1'b1) bad++;
        end
        chk("auto_delay_bad_cycles", bad, 0);
        tick();
        chk_a("auto_e10", 1, 1, 0, 0);
        tick();
        chk_a("auto_e11", 0, 0, 1, 1);
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (pulse_a !== 1'b0 || done_a !== 1'b0 || busy_a !== 1'b0) bad++;
        end
        chk("auto_no_repeat_bad_cycles", bad, 0);

        // Auto-start instance: reset mid-PULSE restarts from DELAY.
        set_cfg(1'b0, 9, 4, 0, 0);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        tick();
        chk_a("auto2_e0", 0, 1, 0, 0);
        for (int k = 1; k <= 11; k++) tick();
        chk_a("auto2_mid_pulse", 1, 1, 0, 0);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        chk_a("auto2_rst", 0, 0, 0, 0);
        tick();
        chk_a("auto2_restart", 0, 1, 0, 0);
        for (int k = 1; k <= 10; k++) tick();
        chk_a("auto2_restart_pulse", 1, 1, 0, 0);
        rst_a = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
